neuron_sequencer: RTL and testbench

//  Time-multiplexes one combinational neuron datapath across N_NEURONS logical neurons.

---
 rtl/neuron_sequencer_pkg.sv | 14 +
 rtl/neuron_sequencer.sv | 100 ++++++++++
 tb/tb_neuron_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/neuron_sequencer_pkg.sv
// neuron_sequencer_pkg: shared widths and FSM encoding for the neuron sequencer
package neuron_sequencer_pkg;

    localparam int N_STAGE = 2;
    localparam int UW      = N_STAGE + 2;
    localparam int FANIN   = 2 ** N_STAGE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/neuron_sequencer.sv
// neuron_sequencer: time-multiplexes one combinational neuron over N_NEURONS logical neurons
module neuron_sequencer
    import neuron_sequencer_pkg::*;
#(
    parameter int  n_stage   = N_STAGE,
    parameter int  N_NEURONS = 4,
    localparam int uw        = n_stage + 2,
    localparam int fanin     = 2 ** n_stage,
    localparam int iw        = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [iw-1:0]        cfg_addr,
    input  logic [fanin-1:0]     cfg_wdata,
    input  logic [2:0]           shift,
    input  logic signed [uw-1:0] threshold,
    input  logic                 start,
    input  logic [fanin-1:0]     x_in,
    output logic [fanin-1:0]     n_w,
    output logic [fanin-1:0]     n_x,
    output logic signed [uw-1:0] n_previus_u,
    output logic                 n_was_spike,
    output logic [2:0]           n_shift,
    output logic signed [uw-1:0] n_threshold,
    input  logic signed [uw-1:0] n_u_out,
    input  logic                 n_is_spike,
    output logic                 busy,
    output logic                 done,
    output logic [N_NEURONS-1:0] spikes_out
);

    state_t               state_q, state_d;
    logic [iw-1:0]        idx_q;
    logic [fanin-1:0]     x_q;
    logic [fanin-1:0]     wgt [N_NEURONS];
    logic signed [uw-1:0] u [N_NEURONS];
    logic [N_NEURONS-1:0] s;
    logic [N_NEURONS-1:0] spk_sh;
    logic                 run;
    logic                 last;
    logic                 accept;
    logic                 cfg_ok;

    // next state, status flags and the combinational operand mux into the neuron
    always_comb begin
        run         = state_q == ST_RUN;
        last        = idx_q == iw'(N_NEURONS - 1);
        accept      = state_q == ST_IDLE && start;
        cfg_ok      = state_q == ST_IDLE && cfg_we && (32'(cfg_addr) < N_NEURONS);
        state_d     = accept ? ST_RUN : (run && last) ? ST_DONE : (state_q == ST_DONE) ? ST_IDLE : state_q;
        busy        = state_q != ST_IDLE;
        done        = state_q == ST_DONE;
        n_w         = wgt[idx_q];
        n_x         = x_q;
        n_previus_u = u[idx_q];
        n_was_spike = s[idx_q];
        n_shift     = shift;
        n_threshold = threshold;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // index walk, input latch and layer spike publish (idx rests at 0 outside RUN)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            x_q        <= '0;
            spikes_out <= '0;
        end else begin
            idx_q      <= run ? (last ? '0 : idx_q + 1'b1) : idx_q;
            x_q        <= accept ? x_in : x_q;
            spikes_out <= done ? spk_sh : spikes_out;
        end
    end

    // weight config in IDLE and per-neuron writeback of the neuron result during RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                wgt[i] <= '0;
                u[i]   <= '0;
            end
            s      <= '0;
            spk_sh <= '0;
        end else begin
            if (cfg_ok) wgt[cfg_addr] <= cfg_wdata;
            if (run) begin
                u[idx_q]      <= n_u_out;
                s[idx_q]      <= n_is_spike;
                spk_sh[idx_q] <= n_is_spike;
            end
        end
    end

endmodule

// File: tb/tb_neuron_sequencer.sv
// tb_neuron_sequencer: scoreboard bench for the sequencer driving a behavioural neuron
module tb_neuron_sequencer;

    logic              clk = 0;
    logic              rst_n = 0;
    logic              cfg_we = 0;
    logic [1:0]        cfg_addr = 0;
    logic [3:0]        cfg_wdata = 0;
    logic [2:0]        shift = 0;
    logic signed [3:0] threshold = 0;
    logic              start = 0;
    logic [3:0]        x_in = 0;
    logic [3:0]        n_w, n_x;
    logic signed [3:0] n_previus_u, n_u_out, n_threshold;
    logic              n_was_spike, n_is_spike, busy, done;
    logic [2:0]        n_shift;
    logic [3:0]        spikes_out;

    typedef struct {logic [3:0] w; logic [3:0] u; logic s; logic [3:0] x;} ev_t;
    typedef struct {int cyc; logic [3:0] spk;} dn_t;

    ev_t evq[$];
    dn_t dq[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    logic       spk_pend = 0;
    logic [3:0] spk_exp = 0;

    neuron_sequencer #(.n_stage(2), .N_NEURONS(4)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .shift(shift), .threshold(threshold), .start(start), .x_in(x_in),
        .n_w(n_w), .n_x(n_x), .n_previus_u(n_previus_u), .n_was_spike(n_was_spike),
        .n_shift(n_shift), .n_threshold(n_threshold), .n_u_out(n_u_out), .n_is_spike(n_is_spike),
        .busy(busy), .done(done), .spikes_out(spikes_out)
    );

    // behavioural neuron: decayed potential (zeroed after a spike) plus weighted input count
    logic signed [3:0] base;
    logic [2:0]        sum;
    always_comb begin
        sum        = 3'($countones(n_w & n_x));
        base       = n_was_spike ? 4'sd0 : (n_previus_u >>> n_shift);
        n_u_out    = base + $signed({1'b0, sum});
        n_is_spike = n_u_out >= n_threshold;
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every RUN cycle consumes one expected evaluation, every done one expected result
    always @(negedge clk) begin
        ev_t e;
        dn_t d;
        if (spk_pend) begin
            check("spikes_out", 32'(spikes_out), 32'(spk_exp));
            spk_pend = 0;
        end
        if (rst_n && busy && !done) begin
            if (evq.size() == 0) check("unexpected_run_cycle", 1, 0);
            else begin
                e = evq.pop_front();
                check("n_w", 32'(n_w), 32'(e.w));
                check("n_x", 32'(n_x), 32'(e.x));
                check("n_previus_u", 32'(n_previus_u), 32'(e.u));
                check("n_was_spike", 32'(n_was_spike), 32'(e.s));
            end
        end
        if (rst_n && done) begin
            if (dq.size() == 0) check("unexpected_done", 1, 0);
            else begin
                d = dq.pop_front();
                check("done_cycle", 32'(cyc), 32'(d.cyc));
                spk_pend = 1;
                spk_exp  = d.spk;
            end
        end
    end

    task automatic ev(input logic [3:0] w, input logic [3:0] u, input logic s);
        evq.push_back('{w: w, u: u, s: s, x: 4'b1111});
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        cfg_we = 1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 0;
    endtask

    // one timestep with x_in=1111; optional same-cycle write of wgt[2], optional illegal cfg/start during RUN
    task automatic run(input logic [3:0] spk, input bit wr_same, input bit guard);
        int k;
        start = 1; x_in = 4'b1111;
        if (wr_same) begin cfg_we = 1; cfg_addr = 2; cfg_wdata = 4'b1111; end
        @(posedge clk); #1;
        start = 0; cfg_we = 0; x_in = 4'b0000;
        dq.push_back('{cyc: cyc + 4, spk: spk});
        if (guard) begin
            start = 1; x_in = 4'b0001; cfg_we = 1; cfg_addr = 0; cfg_wdata = 4'b1111;
            @(posedge clk); #1;
            start = 0; cfg_we = 0; x_in = 4'b0000;
        end
        k = 0;
        while (!done && k < 20) begin @(negedge clk); k++; end
        if (k == 20) check("done_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_spikes_out", 32'(spikes_out), 0);
        check("rst_n_previus_u", 32'(n_previus_u), 0);
        @(posedge clk); #1 rst_n = 1;
        // zero weights
        threshold = 4'sd3;
        for (int i = 0; i < 4; i++) ev(4'b0000, 4'd0, 0);
        run(4'b0000, 0, 0);
        // index walk with distinct weights, then a second step showing writeback of u
        wr(0, 4'b0001); wr(1, 4'b0011); wr(2, 4'b0111); wr(3, 4'b1111);
        threshold = 4'sd7;
        ev(4'b0001, 4'd0, 0); ev(4'b0011, 4'd0, 0); ev(4'b0111, 4'd0, 0); ev(4'b1111, 4'd0, 0);
        run(4'b0000, 0, 0);
        ev(4'b0001, 4'd1, 0); ev(4'b0011, 4'd2, 0); ev(4'b0111, 4'd3, 0); ev(4'b1111, 4'd4, 0);
        run(4'b0000, 0, 0);
        // full reset clears weights and potentials
        rst_n = 0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1;
        // fire: wgt[2] written in the start cycle, then state carry, then guarded run
        threshold = 4'sd3;
        ev(4'b0000, 4'd0, 0); ev(4'b0000, 4'd0, 0); ev(4'b1111, 4'd0, 0); ev(4'b0000, 4'd0, 0);
        run(4'b0100, 1, 0);
        ev(4'b0000, 4'd0, 0); ev(4'b0000, 4'd0, 0); ev(4'b1111, 4'd4, 1); ev(4'b0000, 4'd0, 0);
        run(4'b0100, 0, 1);
        ev(4'b0000, 4'd0, 0); ev(4'b0000, 4'd0, 0); ev(4'b1111, 4'd4, 1); ev(4'b0000, 4'd0, 0);
        run(4'b0100, 0, 0);
        check("spikes_hold", 32'(spikes_out), 32'(4'b0100));
        // reset in cycle 2 of a run
        ev(4'b0000, 4'd0, 0);
        start = 1; x_in = 4'b1111;
        @(posedge clk); #1 start = 0;
        @(posedge clk); #1 rst_n = 0;
        repeat (2) @(negedge clk);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_spikes_out", 32'(spikes_out), 0);
        check("midrst_n_previus_u", 32'(n_previus_u), 0);
        @(posedge clk); #1 rst_n = 1;
        repeat (3) @(posedge clk);
        #1;
        // potentials and spike flags must be cleared after the aborted run
        wr(2, 4'b1111);
        ev(4'b0000, 4'd0, 0); ev(4'b0000, 4'd0, 0); ev(4'b1111, 4'd0, 0); ev(4'b0000, 4'd0, 0);
        run(4'b0100, 0, 0);
        repeat (4) @(negedge clk);
        check("ev_queue_empty", 32'(evq.size()), 0);
        check("done_queue_empty", 32'(dq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
